// File: rtl/sram_stream_uart_tx.sv
// sram_stream_uart_tx: small byte FIFO feeding an 8N1 UART transmitter, with in_ready back-pressure to the upstream sweep.
module sram_stream_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [7:0]         mem_q [DEPTH];
    logic               push, pop, bit_end, has_data;
    assign has_data = count_q != '0;
    assign in_ready = count_q != (FIFO_AW+1)'(DEPTH);
    assign push     = in_valid & in_ready;
    assign bit_end  = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign tx       = tx_q;
    assign busy     = (state_q != IDLE) | has_data;
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (has_data) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: if (bit_end) begin
                state_d = DATA;
                idx_d   = '0;
                tx_d    = shift_q[0];
            end
            DATA: if (bit_end) begin
                if (idx_q == 3'd7) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    tx_d    = shift_q[1];
                end
            end
            STOP: if (bit_end) begin
                // next queued byte starts immediately so frames stay contiguous
                if (has_data) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        wptr_d  = wptr_q + FIFO_AW'(push);
        rptr_d  = rptr_q + FIFO_AW'(pop);
        count_d = count_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= in_data;
    end
endmodule

// File: tb/tb_sram_stream_uart_tx.sv
// tb_sram_stream_uart_tx: directed checks of the FIFO-fed 8N1 transmitter at CLKS_PER_BIT=4, FIFO_AW=2.
module tb_sram_stream_uart_tx;
    logic       clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, tx, busy;
    int         checks = 0, errors = 0, cyc = 0, e0 = 0, e1 = 0, n = 0, lows = 0, bad_busy = 0, bad_ready = 0;
    logic [9:0] rx_f[$];
    int         rx_t[$];
    logic [9:0] fb;
    logic [39:0] got, exp;
    logic       b39;

    sram_stream_uart_tx #(.CLKS_PER_BIT(4), .FIFO_AW(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference receiver: samples each bit in its middle, records frame bits and start edge
    always begin : rx_model
        logic [9:0] fr;
        int s;
        @(negedge clk);
        if (rst && tx === 1'b0) begin
            s = cyc;
            for (int j = 0; j < 10; j++) begin
                repeat (j == 0 ? 2 : 4) @(negedge clk);
                fr[j] = tx;
            end
            rx_f.push_back(fr);
            rx_t.push_back(s);
            @(negedge clk);
        end
    end

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 2000) begin
            tick();
            k++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] b, input int st);
        if (rx_f.size() == 0) begin
            check({tag, "_present"}, 0, 1);
            return;
        end
        check({tag, "_frame"}, rx_f.pop_front(), {1'b1, b, 1'b0});
        check({tag, "_start"}, rx_t.pop_front(), st);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b1;
        tick();

        // single byte, exact waveform
        e0 = cyc;
        send(8'h48);
        check("lat_tx_edge1", tx, 1);
        check("lat_busy_edge1", busy, 1);
        tick();
        fb = {1'b1, 8'h48, 1'b0};
        for (int i = 0; i < 40; i++) begin
            got[i] = tx;
            exp[i] = fb[i/4];
            if (i == 39) b39 = busy;
            tick();
        end
        check("wave_48", got, exp);
        check("busy_edge41", b39, 1);
        check("busy_edge42", busy, 0);
        check("tx_after_48", tx, 1);
        check_rx("b48", 8'h48, e0 + 2);
        tick();

        // burst with back-pressure
        e0 = cyc;
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_data = 8'(k);
            tick();
        end
        check("full_ready", in_ready, 0);
        in_data = 8'h06;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("ready_return_edge", cyc - e0, 42);
        tick();
        in_valid = 1'b0;
        wait_idle();
        check("burst_end_edge", cyc - e0, 242);
        check("burst_frames", rx_f.size(), 6);
        for (int k = 0; k < 6; k++) check_rx("burst", 8'(k + 1), e0 + 2 + 40 * k);
        tick();

        // boundary data
        e0 = cyc;
        send(8'h00);
        wait_idle();
        e1 = cyc;
        send(8'hFF);
        wait_idle();
        check_rx("b00", 8'h00, e0 + 2);
        check_rx("bFF", 8'hFF, e1 + 2);
        tick();

        // push on the same edge as the pop
        e0 = cyc;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        tick();
        check("pp_count1", dut.count_q, 1);
        in_data = 8'hC3;
        check("pp_ready_before", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("pp_count_kept", dut.count_q, 1);
        check("pp_ready_after", in_ready, 1);
        wait_idle();
        check_rx("pp0", 8'h3C, e0 + 2);
        check_rx("pp1", 8'hC3, e0 + 42);
        tick();

        // reset in the middle of data bit 3 with two bytes queued
        in_valid = 1'b1;
        in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_valid = 1'b0;
        repeat (16) tick();
        check("pre_rst_tx", tx, 0);
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("async_tx", tx, 1);
        check("async_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("post_rst_ready", in_ready, 1);
        lows = 0;
        bad_busy = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("post_rst_no_frame", lows, 0);
        check("post_rst_no_busy", bad_busy, 0);
        rx_f.delete();
        rx_t.delete();
        e0 = cyc;
        send(8'hA5);
        wait_idle();
        check_rx("bA5", 8'hA5, e0 + 2);

        // long idle
        lows = 0;
        bad_busy = 0;
        bad_ready = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) bad_busy++;
            if (in_ready !== 1'b1) bad_ready++;
        end
        check("idle_tx", lows, 0);
        check("idle_busy", bad_busy, 0);
        check("idle_ready", bad_ready, 0);
        check("idle_frames", rx_f.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
